// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage sitting directly in front of a combinational instruction memory.
// Owns the PC, drives IMemAddress from it, captures the returned word and
// queues {PC, instruction} pairs in a small FIFO for decode. Redirect flushes
// the queue and reloads the PC; Halt stops new fetches while the queue drains.
//
// Ports:
//   Clk, Rst_n        clock, asynchronous active-low reset
//   Halt              stop issuing fetches (queue still drains)
//   Redirect          flush queue and load RedirectPC (word aligned)
//   RedirectPC        redirect target
//   IMemAddress       instruction memory address (= PC register)
//   IMemInstruction   memory read data for IMemAddress, same cycle
//   IF_Valid          queue head valid
//   IF_Ready          decode accepts the head this cycle
//   IF_Instruction    head instruction (0 when empty)
//   IF_PC             head PC (0 when empty)
//   IF_PCPlus4        head PC + 4 (0 when empty)
//   FetchCount        queue occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Halt,
    input  logic             Redirect,
    input  logic [31:0]      RedirectPC,
    output logic [31:0]      IMemAddress,
    input  logic [31:0]      IMemInstruction,
    output logic             IF_Valid,
    input  logic             IF_Ready,
    output logic [31:0]      IF_Instruction,
    output logic [31:0]      IF_PC,
    output logic [31:0]      IF_PCPlus4,
    output logic [PTR_W:0]   FetchCount
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [31:0]      pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];

    logic push, pop, empty;

    assign empty = (count_q == '0);
    assign pop   = !empty && IF_Ready;
    // A full queue may still accept a fetch when the head leaves this cycle:
    // the write lands in the slot being vacated.
    assign push  = !Redirect && !Halt && ((count_q < CNT_FULL) || pop);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (Redirect) begin
            // A pop in this cycle is still accepted by decode; the flush only
            // discards what remains.
            pc_d     = {RedirectPC[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]    <= pc_q;
            instr_mem_q[wr_ptr_q] <= IMemInstruction;
        end
    end

    // Outputs come only from registers; head fields are masked to 0 when empty.
    assign IMemAddress    = pc_q;
    assign IF_Valid       = !empty;
    assign FetchCount     = count_q;
    assign IF_PC          = empty ? 32'd0 : pc_mem_q[rd_ptr_q];
    assign IF_Instruction = empty ? 32'd0 : instr_mem_q[rd_ptr_q];
    assign IF_PCPlus4     = empty ? 32'd0 : pc_mem_q[rd_ptr_q] + 32'd4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Halt = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = 32'd0;
    logic [31:0] IMemAddress;
    logic [31:0] IMemInstruction;
    logic        IF_Valid;
    logic        IF_Ready = 1'b0;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC;
    logic [31:0] IF_PCPlus4;
    logic [2:0]  FetchCount;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    // Memory word i holds 0x1000_0000 + i.
    assign IMemInstruction = 32'h1000_0000 + (IMemAddress >> 2);

    instruction_fetch_unit #(.RESET_PC(32'h0), .DEPTH(4), .PTR_W(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Halt(Halt), .Redirect(Redirect),
        .RedirectPC(RedirectPC), .IMemAddress(IMemAddress),
        .IMemInstruction(IMemInstruction), .IF_Valid(IF_Valid),
        .IF_Ready(IF_Ready), .IF_Instruction(IF_Instruction), .IF_PC(IF_PC),
        .IF_PCPlus4(IF_PCPlus4), .FetchCount(FetchCount)
    );

    // One clock edge, then settle to the falling edge for sampling/driving.
    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic apply_reset(input logic ready);
        @(negedge Clk);
        Rst_n = 1'b0; Halt = 1'b0; Redirect = 1'b0; IF_Ready = ready;
        #1;
        Rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Rst_n = 1'b0; IF_Ready = 1'b1;
        #1;
        checks++; if (IF_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", IF_Valid); end
        checks++; if (FetchCount !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", FetchCount); end
        checks++; if (IMemAddress !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", IMemAddress); end
        checks++; if ({IF_PC, IF_Instruction, IF_PCPlus4} !== 96'h0) begin
            errors++; $display("FAIL reset_head got %h %h %h want 0", IF_PC, IF_Instruction, IF_PCPlus4); end
        Rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        step();
        for (int k = 0; k < 5; k++) begin
            checks++; if (IF_Valid !== 1'b1 || FetchCount !== 3'd1) begin
                errors++; $display("FAIL free_run_valid[%0d] got v=%0b cnt=%0d want v=1 cnt=1", k, IF_Valid, FetchCount); end
            checks++; if (IF_PC !== 32'(4 * k) || IF_Instruction !== 32'h1000_0000 + 32'(k)) begin
                errors++; $display("FAIL free_run_head[%0d] got pc=%h ins=%h want pc=%h ins=%h",
                                   k, IF_PC, IF_Instruction, 32'(4 * k), 32'h1000_0000 + 32'(k)); end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] exp_cnt [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
        apply_reset(1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            checks++; if (FetchCount !== exp_cnt[k]) begin
                errors++; $display("FAIL bp_count[%0d] got %0d want %0d", k, FetchCount, exp_cnt[k]); end
        end
        checks++; if (IMemAddress !== 32'h10) begin errors++; $display("FAIL bp_pc_hold got %h want 10", IMemAddress); end
        // Release: full queue with push+pop each cycle (count stays 4).
        IF_Ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++; if (IF_PC !== 32'(4 * k) || IF_Instruction !== 32'h1000_0000 + 32'(k)) begin
                errors++; $display("FAIL bp_order[%0d] got pc=%h ins=%h want pc=%h", k, IF_PC, IF_Instruction, 32'(4 * k)); end
            checks++; if (FetchCount !== 3'd4 || IMemAddress !== 32'h10 + 32'(4 * k)) begin
                errors++; $display("FAIL full_pushpop[%0d] got cnt=%0d addr=%h want cnt=4 addr=%h",
                                   k, FetchCount, IMemAddress, 32'h10 + 32'(4 * k)); end
            step();
        end
    endtask

    task automatic test_redirect();
        apply_reset(1'b0);
        step(); step(); step();
        checks++; if (FetchCount !== 3'd3) begin errors++; $display("FAIL redir_pre_count got %0d want 3", FetchCount); end
        IF_Ready = 1'b1; Redirect = 1'b1; RedirectPC = 32'h0000_0203;
        step();
        Redirect = 1'b0;
        checks++; if (FetchCount !== 3'd0 || IF_Valid !== 1'b0) begin
            errors++; $display("FAIL redir_flush got cnt=%0d v=%0b want 0 0", FetchCount, IF_Valid); end
        checks++; if (IMemAddress !== 32'h200) begin errors++; $display("FAIL redir_addr got %h want 200", IMemAddress); end
        step();
        checks++; if (IF_PC !== 32'h200 || IF_Instruction !== 32'h1000_0080 || IF_PCPlus4 !== 32'h204) begin
            errors++; $display("FAIL redir_target got pc=%h ins=%h p4=%h want 200 10000080 204", IF_PC, IF_Instruction, IF_PCPlus4); end
    endtask

    task automatic test_halt();
        logic [2:0] exp_cnt [5] = '{3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
        // Continue from redirect: head 0x200, PC 0x204. Fill to 3 entries.
        IF_Ready = 1'b0;
        step(); step();
        checks++; if (FetchCount !== 3'd3 || IMemAddress !== 32'h20C) begin
            errors++; $display("FAIL halt_pre got cnt=%0d addr=%h want 3 20c", FetchCount, IMemAddress); end
        Halt = 1'b1; IF_Ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (FetchCount !== exp_cnt[k] || IMemAddress !== 32'h20C) begin
                errors++; $display("FAIL halt_drain[%0d] got cnt=%0d addr=%h want %0d 20c", k, FetchCount, IMemAddress, exp_cnt[k]); end
        end
        Halt = 1'b0;
        step();
        checks++; if (IF_Valid !== 1'b1 || IF_PC !== 32'h20C || IMemAddress !== 32'h210) begin
            errors++; $display("FAIL halt_resume got v=%0b pc=%h addr=%h want 1 20c 210", IF_Valid, IF_PC, IMemAddress); end
    endtask

    task automatic test_halt_redirect();
        Halt = 1'b1; Redirect = 1'b1; RedirectPC = 32'h0000_0400;
        step();
        Redirect = 1'b0;
        checks++; if (FetchCount !== 3'd0 || IMemAddress !== 32'h400) begin
            errors++; $display("FAIL halt_redirect got cnt=%0d addr=%h want 0 400", FetchCount, IMemAddress); end
        step();
        checks++; if (FetchCount !== 3'd0 || IMemAddress !== 32'h400) begin
            errors++; $display("FAIL halt_redirect_hold got cnt=%0d addr=%h want 0 400", FetchCount, IMemAddress); end
        Halt = 1'b0;
        step(); step();
    endtask

    task automatic test_async_reset();
        IF_Ready = 1'b0;
        step();
        checks++; if (FetchCount === 3'd0) begin errors++; $display("FAIL async_pre got cnt=0 want nonzero"); end
        #2;
        Rst_n = 1'b0;
        #1;
        checks++; if (IF_Valid !== 1'b0 || FetchCount !== 3'd0 || IMemAddress !== 32'h0 || IF_PC !== 32'h0) begin
            errors++; $display("FAIL async_reset got v=%0b cnt=%0d addr=%h pc=%h want 0", IF_Valid, FetchCount, IMemAddress, IF_PC); end
        #1;
        Rst_n = 1'b1;
    endtask

    task automatic test_pc_wrap();
        apply_reset(1'b0);
        Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
        step();
        Redirect = 1'b0;
        checks++; if (IMemAddress !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h want fffffffc", IMemAddress); end
        step();
        checks++; if (IF_PC !== 32'hFFFF_FFFC || IF_PCPlus4 !== 32'h0 || IF_Instruction !== 32'h4FFF_FFFF) begin
            errors++; $display("FAIL wrap_head got pc=%h p4=%h ins=%h want fffffffc 0 4fffffff", IF_PC, IF_PCPlus4, IF_Instruction); end
        checks++; if (IMemAddress !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want 0", IMemAddress); end
        IF_Ready = 1'b1;
        step();
        checks++; if (IF_PC !== 32'h0 || IF_Instruction !== 32'h1000_0000 || FetchCount !== 3'd1) begin
            errors++; $display("FAIL wrap_next got pc=%h ins=%h cnt=%0d want 0 10000000 1", IF_PC, IF_Instruction, FetchCount); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_backpressure();
        test_redirect();
        test_halt();
        test_halt_redirect();
        test_async_reset();
        test_pc_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the combinational instruction memory: owns the program counter, drives the memory Address port, and captures the returned Instruction.
- Buffers fetched {PC, instruction} pairs in a small FIFO and presents them to decode through a valid/ready handshake.
- Supports redirect (branch/jump) with flush, and halt.
- One instance per core.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- PTR_W, 2: log2(DEPTH).

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous, active-low reset.
- Halt  input  1  when 1, no new fetches are issued; the FIFO still drains.
- Redirect  input  1  when 1, flush and load RedirectPC.
- RedirectPC  input  32  redirect target; bits [1:0] are forced to 0.
- IMemAddress  output  32  equals the PC register (combinational from it).
- IMemInstruction  input  32  instruction memory read data, valid in the same cycle as IMemAddress.
- IF_Valid  output  1  the FIFO head is valid.
- IF_Ready  input  1  decode accepts the head this cycle.
- IF_Instruction  output  32  instruction at the FIFO head.
- IF_PC  output  32  PC of the FIFO head.
- IF_PCPlus4  output  32  IF_PC + 4, mod 2^32.
- FetchCount  output  PTR_W+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- **Reset (Rst_n = 0, asynchronous):**
  - PC = RESET_PC.
  - Read pointer = write pointer = 0; FetchCount = 0; IF_Valid = 0.
  - IF_Instruction, IF_PC and IF_PCPlus4 are 0 while the FIFO is empty.
  - All state returns to reset immediately, including mid-redirect or mid-handshake.
- **Handshake:**
  - pop = IF_Valid & IF_Ready.
  - push = !Redirect & !Halt & (FetchCount < DEPTH | pop).
  - Push may occur when full only if a pop happens in the same cycle.
- **Fetch:**
  - On push at a clock edge: write {PC, IMemInstruction} into the FIFO, then PC <= PC + 4.
  - Fetch latency is 0: memory read is combinational. An instruction pushed at edge N is visible on IF_* after edge N if the FIFO was empty.
- **Occupancy:**
  - FetchCount' = FetchCount + push - pop.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- **Redirect (highest priority):**
  - At the edge: FIFO emptied (pointers reset, count 0) and PC <= {RedirectPC[31:2], 2'b00}.
  - A pop asserted in the redirect cycle counts as accepted; decode owns that instruction.
  - No push occurs in the redirect cycle.
  - The first fetch from the target is pushed on the following edge, provided Halt = 0.
- **Halt:**
  - PC is frozen and no push occurs; pops continue.
  - Redirect during Halt still flushes and loads the PC.
- **PC wrap:** PC + 4 wraps mod 2^32 (32'hFFFF_FFFC -> 0). No bounds check against memory size.
- **Output timing:** IF_* outputs are driven from the FIFO head registers, with no combinational path from IMemInstruction. IF_Valid = (FetchCount != 0).
- **Sizing:** no FSM beyond the FIFO pointers; implementation roughly 150-250 lines.

Test Plan:
1. **Reset then free run.** Memory word i = 32'h1000_0000 + i, IF_Ready = 1, Halt = 0.
   - After the first edge: IF_Valid = 1, IF_PC = 0, IF_Instruction = 32'h1000_0000.
   - Then one instruction per cycle with PC stepping by 4.
2. **Backpressure.** IF_Ready = 0 for 8 cycles.
   - FetchCount reaches 4 and holds; PC holds at 32'h10.
   - Release: heads pop in order PC 0, 4, 8, C, then 10, with no loss or duplication.
3. **Full FIFO with simultaneous push/pop.** FetchCount = 4, IF_Ready = 1.
   - Count stays 4; PC advances 4 per cycle.
4. **Redirect.** Redirect = 1 with RedirectPC = 32'h0000_0203 while FIFO count = 3, IF_Ready = 1.
   - Next cycle: FetchCount = 0, IF_Valid = 0, IMemAddress = 32'h200.
   - Following cycle: IF_PC = 32'h200.
5. **Halt.** Halt = 1 for 5 cycles with IF_Ready = 1.
   - FIFO drains to 0; IMemAddress is constant.
   - Deassert: fetch resumes at the frozen PC.
6. **Async reset mid-run and PC wrap.** Assert Rst_n = 0 between clock edges.
   - Outputs clear before the next edge.
   - Separately, redirect to 32'hFFFF_FFFC: the next fetched PC is 32'h0 and IF_PCPlus4 of the first entry is 0.
